// File: rtl/dcache_req_arbiter.sv
// ============================================================================
//  Module      : dcache_req_arbiter
//  Description : Shares the single Dcache request port between the load
//                buffer and the store buffer. A winner is picked whenever the
//                1-entry output slot can accept a request. Its fields are
//                registered into the slot, and a combinational success strobe
//                goes back to the winning requester in the same cycle.
//
//  Ports
//    Clk, Rest                      clock (rising edge), async active-low reset
//    ArbFlash                       pipeline flush: blocks load grants and
//                                   drops a held load
//    LbReqAble/Mat/Ptr/Addr         load buffer request
//    LbReqSuccess                   load captured this cycle (combinational)
//    SbReqAble/Addr/Data/Mask       store buffer request
//    SbReqSuccess                   store captured this cycle (combinational)
//    DcReqValid/Ready               slot handshake towards the Dcache
//    DcReqWrite/Mat/Ptr/Addr/
//    DcReqData/Mask                 registered slot contents
//
//  Configuration macro
//    ARB_ROUND_ROBIN_EN  defined   : alternate load/store on conflict (RrLast)
//                        undefined : load priority, with a starvation counter
//                                    that forces a pending store through
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dcache_req_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        Clk,
    input  logic        Rest,
    input  logic        ArbFlash,
    input  logic        LbReqAble,
    input  logic [1:0]  LbReqMat,
    input  logic [2:0]  LbReqPtr,
    input  logic [31:0] LbReqAddr,
    output logic        LbReqSuccess,
    input  logic        SbReqAble,
    input  logic [31:0] SbReqAddr,
    input  logic [31:0] SbReqData,
    input  logic [3:0]  SbReqMask,
    output logic        SbReqSuccess,
    output logic        DcReqValid,
    input  logic        DcReqReady,
    output logic        DcReqWrite,
    output logic [1:0]  DcReqMat,
    output logic [2:0]  DcReqPtr,
    output logic [31:0] DcReqAddr,
    output logic [31:0] DcReqData,
    output logic [3:0]  DcReqMask
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_HELD  = 1'b1
    } slot_state_t;

    slot_state_t r_state;
    slot_state_t w_next_state;

    logic        r_write;
    logic [1:0]  r_mat;
    logic [2:0]  r_ptr;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_mask;

    logic w_cap;
    logic w_store_win;
    logic w_load_win;
    logic w_store_grant;
    logic w_load_grant;

    // The slot can take a new request when empty or when it drains this cycle.
    assign w_cap = (r_state == SLOT_EMPTY) | DcReqReady;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = the last captured request was a load, so a store wins the next
    // conflict. Reset value 0 makes the first conflict go to the load.
    logic r_rr_last;

    assign w_store_win = SbReqAble & (~LbReqAble | r_rr_last);

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_rr_last <= 1'b0;
        end else if (w_store_grant) begin
            r_rr_last <= 1'b0;
        end else if (w_load_grant) begin
            r_rr_last <= 1'b1;
        end
    end
`else
    localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_store_win = SbReqAble & (~LbReqAble | (r_starve_cnt >= c_starve_limit));

    // Counts the loads that overtook a waiting store; any cycle without a
    // pending store forgets the history.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_starve_cnt <= '0;
        end else if (!SbReqAble || w_store_grant) begin
            r_starve_cnt <= '0;
        end else if (w_load_grant && (r_starve_cnt != c_cnt_max)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end
`endif

    // A flush suppresses the load grant outright. The store rule stays
    // untouched, so a store only wins where it would have won anyway.
    assign w_load_win = LbReqAble & ~w_store_win & ~ArbFlash;

    // Gating with Rest keeps the strobes low while reset is asserted,
    // including a reset that lands mid-cycle.
    assign w_store_grant = w_cap & w_store_win & Rest;
    assign w_load_grant  = w_cap & w_load_win  & Rest;

    assign LbReqSuccess = w_load_grant;
    assign SbReqSuccess = w_store_grant;

    always_comb begin
        w_next_state = r_state;
        if (w_cap) begin
            w_next_state = (w_store_grant || w_load_grant) ? SLOT_HELD : SLOT_EMPTY;
        end else if (ArbFlash && !r_write) begin
            // A stalled load is speculative and is discarded on flush.
            // A stalled store is committed and stays put.
            w_next_state = SLOT_EMPTY;
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Slot payload is written only on a grant, so it is frozen while the slot
    // is held and not accepted.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            r_write <= 1'b0;
            r_mat   <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= '0;
        end else if (w_store_grant) begin
            r_write <= 1'b1;
            r_mat   <= '0;
            r_ptr   <= '0;
            r_addr  <= SbReqAddr;
            r_data  <= SbReqData;
            r_mask  <= SbReqMask;
        end else if (w_load_grant) begin
            r_write <= 1'b0;
            r_mat   <= LbReqMat;
            r_ptr   <= LbReqPtr;
            r_addr  <= LbReqAddr;
            r_data  <= '0;
            r_mask  <= '0;
        end
    end

    assign DcReqValid = (r_state == SLOT_HELD);
    assign DcReqWrite = r_write;
    assign DcReqMat   = r_mat;
    assign DcReqPtr   = r_ptr;
    assign DcReqAddr  = r_addr;
    assign DcReqData  = r_data;
    assign DcReqMask  = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_dcache_req_arbiter.sv
// ============================================================================
//  Module      : tb_dcache_req_arbiter
//  Description : Directed self-checking bench for dcache_req_arbiter.
//                Inputs change 1 ns after the rising edge. Strobes are sampled
//                at the falling edge, and registered outputs 1 ns after the
//                rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dcache_req_arbiter;

    logic        Clk = 1'b0;
    logic        Rest;
    logic        ArbFlash;
    logic        LbReqAble;
    logic [1:0]  LbReqMat;
    logic [2:0]  LbReqPtr;
    logic [31:0] LbReqAddr;
    logic        LbReqSuccess;
    logic        SbReqAble;
    logic [31:0] SbReqAddr;
    logic [31:0] SbReqData;
    logic [3:0]  SbReqMask;
    logic        SbReqSuccess;
    logic        DcReqValid;
    logic        DcReqReady;
    logic        DcReqWrite;
    logic [1:0]  DcReqMat;
    logic [2:0]  DcReqPtr;
    logic [31:0] DcReqAddr;
    logic [31:0] DcReqData;
    logic [3:0]  DcReqMask;

    int checks   = 0;
    int failures = 0;

    dcache_req_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .Clk          (Clk),
        .Rest         (Rest),
        .ArbFlash     (ArbFlash),
        .LbReqAble    (LbReqAble),
        .LbReqMat     (LbReqMat),
        .LbReqPtr     (LbReqPtr),
        .LbReqAddr    (LbReqAddr),
        .LbReqSuccess (LbReqSuccess),
        .SbReqAble    (SbReqAble),
        .SbReqAddr    (SbReqAddr),
        .SbReqData    (SbReqData),
        .SbReqMask    (SbReqMask),
        .SbReqSuccess (SbReqSuccess),
        .DcReqValid   (DcReqValid),
        .DcReqReady   (DcReqReady),
        .DcReqWrite   (DcReqWrite),
        .DcReqMat     (DcReqMat),
        .DcReqPtr     (DcReqPtr),
        .DcReqAddr    (DcReqAddr),
        .DcReqData    (DcReqData),
        .DcReqMask    (DcReqMask)
    );

    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        ArbFlash   = 1'b0;
        LbReqAble  = 1'b0;
        LbReqMat   = 2'd0;
        LbReqPtr   = 3'd0;
        LbReqAddr  = 32'h0;
        SbReqAble  = 1'b0;
        SbReqAddr  = 32'h0;
        SbReqData  = 32'h0;
        SbReqMask  = 4'h0;
        DcReqReady = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        Rest      = 1'b0;
        LbReqAble = 1'b1;
        LbReqPtr  = 3'd1;
        #2;
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%0h required=0", DcReqValid); end
        checks++; if (LbReqSuccess !== 1'b0) begin failures++; $display("FAIL rst_lb_strobe actual=%0h required=0", LbReqSuccess); end
        cyc(); cyc();
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL rst_valid_hold actual=%0h required=0", DcReqValid); end
        Rest = 1'b1;
        LbReqAble = 1'b0;
        cyc();
        // Build a held load, then pull reset in the middle of the cycle.
        LbReqAble  = 1'b1;
        LbReqPtr   = 3'd2;
        LbReqAddr  = 32'h20;
        DcReqReady = 1'b0;
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b1) begin failures++; $display("FAIL rst_pre_capture actual=%0h required=1", LbReqSuccess); end
        cyc();
        checks++; if (DcReqValid !== 1'b1) begin failures++; $display("FAIL rst_pre_held actual=%0h required=1", DcReqValid); end
        SbReqAble  = 1'b1;
        DcReqReady = 1'b1;
        #2;
        Rest = 1'b0;
        #1;
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid actual=%0h required=0", DcReqValid); end
        checks++; if (LbReqSuccess !== 1'b0) begin failures++; $display("FAIL rst_mid_lb actual=%0h required=0", LbReqSuccess); end
        checks++; if (SbReqSuccess !== 1'b0) begin failures++; $display("FAIL rst_mid_sb actual=%0h required=0", SbReqSuccess); end
        cyc();
        idle();
        Rest = 1'b1;
        cyc();
    endtask

    task automatic test_load_only();
        LbReqAble  = 1'b1;
        LbReqPtr   = 3'd3;
        LbReqAddr  = 32'h1000;
        LbReqMat   = 2'd2;
        DcReqReady = 1'b1;
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b1) begin failures++; $display("FAIL ld_strobe actual=%0h required=1", LbReqSuccess); end
        checks++; if (SbReqSuccess !== 1'b0) begin failures++; $display("FAIL ld_sb_strobe actual=%0h required=0", SbReqSuccess); end
        cyc();
        LbReqAble = 1'b0;
        checks++; if (DcReqValid !== 1'b1) begin failures++; $display("FAIL ld_valid actual=%0h required=1", DcReqValid); end
        checks++; if (DcReqWrite !== 1'b0) begin failures++; $display("FAIL ld_write actual=%0h required=0", DcReqWrite); end
        checks++; if (DcReqPtr !== 3'd3) begin failures++; $display("FAIL ld_ptr actual=%0h required=3", DcReqPtr); end
        checks++; if (DcReqAddr !== 32'h1000) begin failures++; $display("FAIL ld_addr actual=%0h required=1000", DcReqAddr); end
        checks++; if (DcReqMat !== 2'd2) begin failures++; $display("FAIL ld_mat actual=%0h required=2", DcReqMat); end
        checks++; if (DcReqData !== 32'h0 || DcReqMask !== 4'h0) begin failures++; $display("FAIL ld_zero_fields actual=%0h/%0h required=0/0", DcReqData, DcReqMask); end
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b0) begin failures++; $display("FAIL ld_no_req_strobe actual=%0h required=0", LbReqSuccess); end
        cyc();
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL ld_drain actual=%0h required=0", DcReqValid); end
    endtask

    task automatic test_backpressure();
        LbReqAble  = 1'b1;
        LbReqPtr   = 3'd5;
        LbReqAddr  = 32'h2000;
        LbReqMat   = 2'd1;
        DcReqReady = 1'b0;
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b1) begin failures++; $display("FAIL bp_first actual=%0h required=1", LbReqSuccess); end
        cyc();
        LbReqPtr  = 3'd6;
        LbReqAddr = 32'h3000;
        SbReqAble = 1'b1;
        SbReqAddr = 32'h4000;
        SbReqData = 32'hCAFE;
        SbReqMask = 4'h3;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++; if (LbReqSuccess !== 1'b0 || SbReqSuccess !== 1'b0) begin failures++; $display("FAIL bp_strobe[%0d] actual=%0b%0b required=00", i, LbReqSuccess, SbReqSuccess); end
            checks++; if (DcReqValid !== 1'b1 || DcReqPtr !== 3'd5 || DcReqAddr !== 32'h2000) begin failures++; $display("FAIL bp_hold[%0d] actual=%0h/%0h/%0h required=1/5/2000", i, DcReqValid, DcReqPtr, DcReqAddr); end
            cyc();
        end
        DcReqReady = 1'b1;
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b1 || SbReqSuccess !== 1'b0) begin failures++; $display("FAIL bp_refill_strobe actual=%0b%0b required=10", LbReqSuccess, SbReqSuccess); end
        cyc();
        checks++; if (DcReqValid !== 1'b1 || DcReqPtr !== 3'd6 || DcReqAddr !== 32'h3000) begin failures++; $display("FAIL bp_refill actual=%0h/%0h/%0h required=1/6/3000", DcReqValid, DcReqPtr, DcReqAddr); end
        LbReqAble = 1'b0;
        @(negedge Clk);
        checks++; if (SbReqSuccess !== 1'b1) begin failures++; $display("FAIL bp_store_strobe actual=%0h required=1", SbReqSuccess); end
        cyc();
        SbReqAble = 1'b0;
        checks++; if (DcReqWrite !== 1'b1 || DcReqAddr !== 32'h4000) begin failures++; $display("FAIL st_write_addr actual=%0h/%0h required=1/4000", DcReqWrite, DcReqAddr); end
        checks++; if (DcReqData !== 32'hCAFE || DcReqMask !== 4'h3) begin failures++; $display("FAIL st_data_mask actual=%0h/%0h required=cafe/3", DcReqData, DcReqMask); end
        checks++; if (DcReqPtr !== 3'd0 || DcReqMat !== 2'd0) begin failures++; $display("FAIL st_zero_fields actual=%0h/%0h required=0/0", DcReqPtr, DcReqMat); end
        cyc();
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL bp_drain actual=%0h required=0", DcReqValid); end
    endtask

    task automatic test_arbitration();
        logic        exp_store;
        logic [31:0] exp_addr;
        Rest = 1'b0;
        #1;
        Rest = 1'b1;
        idle();
        cyc();
        LbReqAble  = 1'b1;
        SbReqAble  = 1'b1;
        LbReqPtr   = 3'd4;
        SbReqMask  = 4'hF;
        DcReqReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            LbReqAddr = 32'h100 + i;
            SbReqAddr = 32'h800 + i;
            SbReqData = 32'hD000 + i;
`ifdef ARB_ROUND_ROBIN_EN
            exp_store = (i % 2) == 1;
`else
            exp_store = (i % 5) == 4;
`endif
            exp_addr = exp_store ? (32'h800 + i) : (32'h100 + i);
            @(negedge Clk);
            checks++; if (LbReqSuccess !== ~exp_store || SbReqSuccess !== exp_store) begin failures++; $display("FAIL arb_strobe[%0d] actual=L%0b,S%0b required=L%0b,S%0b", i, LbReqSuccess, SbReqSuccess, ~exp_store, exp_store); end
            cyc();
            checks++; if (DcReqWrite !== exp_store || DcReqAddr !== exp_addr) begin failures++; $display("FAIL arb_slot[%0d] actual=%0h/%0h required=%0h/%0h", i, DcReqWrite, DcReqAddr, exp_store, exp_addr); end
        end
        idle();
        cyc();
    endtask

    task automatic test_flush();
        LbReqAble  = 1'b1;
        LbReqPtr   = 3'd7;
        LbReqAddr  = 32'h5000;
        DcReqReady = 1'b0;
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b1) begin failures++; $display("FAIL fl_ld_capture actual=%0h required=1", LbReqSuccess); end
        cyc();
        ArbFlash  = 1'b1;
        LbReqPtr  = 3'd1;
        LbReqAddr = 32'h6000;
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b0 || SbReqSuccess !== 1'b0) begin failures++; $display("FAIL fl_ld_strobe actual=%0b%0b required=00", LbReqSuccess, SbReqSuccess); end
        cyc();
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL fl_ld_drop actual=%0h required=0", DcReqValid); end
        @(negedge Clk);
        checks++; if (LbReqSuccess !== 1'b0) begin failures++; $display("FAIL fl_empty_block actual=%0h required=0", LbReqSuccess); end
        cyc();
        ArbFlash  = 1'b0;
        LbReqAble = 1'b0;
        SbReqAble = 1'b1;
        SbReqAddr = 32'h7000;
        SbReqData = 32'h1234;
        SbReqMask = 4'hC;
        @(negedge Clk);
        checks++; if (SbReqSuccess !== 1'b1) begin failures++; $display("FAIL fl_st_capture actual=%0h required=1", SbReqSuccess); end
        cyc();
        SbReqAble = 1'b0;
        ArbFlash  = 1'b1;
        cyc();
        checks++; if (DcReqValid !== 1'b1 || DcReqWrite !== 1'b1 || DcReqAddr !== 32'h7000) begin failures++; $display("FAIL fl_st_retain actual=%0h/%0h/%0h required=1/1/7000", DcReqValid, DcReqWrite, DcReqAddr); end
        DcReqReady = 1'b1;
        SbReqAble  = 1'b1;
        SbReqAddr  = 32'h7100;
        @(negedge Clk);
        checks++; if (SbReqSuccess !== 1'b1) begin failures++; $display("FAIL fl_st_grant actual=%0h required=1", SbReqSuccess); end
        cyc();
        checks++; if (DcReqValid !== 1'b1 || DcReqAddr !== 32'h7100) begin failures++; $display("FAIL fl_st_refill actual=%0h/%0h required=1/7100", DcReqValid, DcReqAddr); end
        idle();
        cyc();
        checks++; if (DcReqValid !== 1'b0) begin failures++; $display("FAIL fl_drain actual=%0h required=0", DcReqValid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_only();
        test_backpressure();
        test_arbitration();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
